rom_stream_reader: RTL and testbench

Reads a contiguous block of words from a synchronous ROM and delivers them as a valid/ready stream. Sits directly upstream of the `rom1`/`rom2` ROM instances. It drives their address and clock-enable pins, captures their registered `Q` output, and buffers the data in a small FIFO so a downstream consumer can apply backpressure without losing ROM words.

---
 rtl/rom_stream_reader_if.sv | 12 +
 rtl/rom_stream_reader.sv | 153 +++++++++++++++
 tb/tb_rom_stream_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// Output stream of rom_stream_reader: FIFO head data plus valid/ready handshake.
// A word moves in every cycle where VALID_O and READY_I are both 1. Once VALID_O rises it stays high, and DATA_O holds steady, until that transfer happens. VALID_O never depends combinationally on READY_I.
interface rom_stream_reader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] DATA_O;
  logic          VALID_O;
  logic          READY_I;

  modport master (output DATA_O, output VALID_O, input READY_I);
  modport slave  (input DATA_O, input VALID_O, output READY_I);
endinterface

// File: rtl/rom_stream_reader.sv
// Streams LEN consecutive words from a synchronous ROM, starting at BASE, through a credit-guarded FIFO.
// An address is issued only when the FIFO is guaranteed room, so words are never lost under backpressure.
module rom_stream_reader #(
  parameter int AW         = 14,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   CLK_I,
  input  logic                   nRST_I,
  input  logic                   START_I,
  input  logic [AW-1:0]          BASE_I,
  input  logic [AW:0]            LEN_I,
  output logic                   BUSY_O,
  output logic                   DONE_O,
  output logic [AW-1:0]          ROM_ADDR_O,
  output logic                   ROM_CLK_EN_O,
  input  logic [DW-1:0]          ROM_Q_I,
  rom_stream_reader_if.master    strm,
  output logic [1:0]             dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [DW-1:0]   mem_d [FIFO_DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic done;

  // Credits count FIFO words plus words still in the ROM pipe; a pop only frees a credit one cycle later.
  assign issue = (state_q == S_ISSUE) && (rem_q != '0) &&
                 (({1'b0, cnt_q} + {1'b0, inflight_q}) < DEPTH_W);
  assign push  = tag_q[RD_LAT-1];
  assign pop   = strm.VALID_O && strm.READY_I;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    last_addr_d = last_addr_q;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START_I) begin
          addr_d  = BASE_I;
          rem_d   = LEN_I;
          state_d = (LEN_I != '0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          last_addr_d = addr_q;
          addr_d      = addr_q + AW'(1);
          rem_d       = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && (cnt_q == '0)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read pipeline: each stage carries a tag that says a real issue happened; the final stage fires the FIFO write.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    inflight_d = inflight_q;
    unique case ({issue, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = ROM_Q_I;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      inflight_q  <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  // When no issue is pending, the ROM sees the last address it was given, not the next one queued up.
  assign ROM_ADDR_O   = issue ? addr_q : last_addr_q;
  assign BUSY_O       = (state_q != S_IDLE);
  assign ROM_CLK_EN_O = BUSY_O;
  assign DONE_O       = done;
  assign strm.VALID_O = (cnt_q != '0);
  assign strm.DATA_O  = mem_q[rd_ptr_q];
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: behavioural ROMs, a table of directed transfers, random transfers,
// a mid-transfer reset, and a second instance with RD_LAT=2.
module tb_rom_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start, start2;
  logic [13:0] base, base2;
  logic [14:0] len, len2;
  logic        busy, busy2, done, done2;
  logic [13:0] rom_addr, rom_addr2;
  logic        rom_en, rom_en2;
  logic [7:0]  rom_q, rom_q2;
  logic [1:0]  dbg_state, dbg_state2;

  rom_stream_reader_if #(.DW(8)) s_if ();
  rom_stream_reader_if #(.DW(8)) s2_if ();

  rom_stream_reader #(.AW(14), .DW(8), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .CLK_I(clk), .nRST_I(rst_n), .START_I(start), .BASE_I(base), .LEN_I(len),
    .BUSY_O(busy), .DONE_O(done), .ROM_ADDR_O(rom_addr), .ROM_CLK_EN_O(rom_en),
    .ROM_Q_I(rom_q), .strm(s_if), .dbg_state_o(dbg_state)
  );

  rom_stream_reader #(.AW(14), .DW(8), .RD_LAT(2), .FIFO_DEPTH(4)) dut2 (
    .CLK_I(clk), .nRST_I(rst_n), .START_I(start2), .BASE_I(base2), .LEN_I(len2),
    .BUSY_O(busy2), .DONE_O(done2), .ROM_ADDR_O(rom_addr2), .ROM_CLK_EN_O(rom_en2),
    .ROM_Q_I(rom_q2), .strm(s2_if), .dbg_state_o(dbg_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM content and models ----------------
  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  logic [7:0] rom1_p0;
  logic [7:0] rom2_p0, rom2_p1;
  always @(posedge clk) if (rom_en) rom1_p0 <= rom_fn(rom_addr);
  always @(posedge clk) if (rom_en2) begin
    rom2_p0 <= rom_fn(rom_addr2);
    rom2_p1 <= rom2_p0;
  end
  assign rom_q  = rom1_p0;
  assign rom_q2 = rom2_p1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one transfer on dut ----------------
  task automatic run_xfer(input logic [13:0] b, input logic [14:0] n, input int mode,
                          input bit extra, output int first_v, output int done_c);
    int cyc;
    int ndone;
    int nwords;
    int last_pop;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [13:0] addr_seen[$];
    for (int i = 0; i < int'(n); i++) exp_q.push_back(rom_fn(b + 14'(i)));
    base = b; len = n; start = 1'b1;
    first_v = -1; done_c = -1; ndone = 0; nwords = 0; last_pop = 0;
    prev_stall = 1'b0; prev_data = '0; cyc = 0;
    while (cyc < 3000 && !(done_c >= 0 && cyc >= done_c + 2)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (extra && cyc == 3) begin
        start = 1'b1; base = 14'h2AAA; len = 15'd5;
      end
      case (mode)
        0:       s_if.READY_I = 1'b1;
        1:       s_if.READY_I = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        2:       s_if.READY_I = 1'($urandom_range(0, 1));
        default: s_if.READY_I = (cyc > 12);
      endcase
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = cyc;
      end
      chk("busy", busy, (done_c < 0) || (cyc == done_c));
      chk("clk_en", rom_en, (done_c < 0) || (cyc == done_c));
      if (n != 0) begin
        if (cyc == 1) addr_seen.push_back(rom_addr);
        else if (rom_addr != addr_seen[$]) addr_seen.push_back(rom_addr);
      end
      if (prev_stall) begin
        chk("stall_valid", s_if.VALID_O, 1);
        chk("stall_data", s_if.DATA_O, prev_data);
      end
      if (s_if.VALID_O) begin
        if (first_v < 0) first_v = cyc;
        if (s_if.READY_I) begin
          nwords++;
          last_pop = cyc;
          if (exp_q.size() == 0) chk("extra_word", 1, 0);
          else chk("data", s_if.DATA_O, exp_q.pop_front());
        end
      end
      if (mode == 3 && cyc == 12) chk("stall_addr", rom_addr, 14'(b + 14'd3));
      prev_stall = s_if.VALID_O && !s_if.READY_I;
      prev_data  = s_if.DATA_O;
    end
    start = 1'b0;
    if (done_c < 0) chk("timeout_done", 0, 1);
    chk("words", nwords, n);
    chk("done_count", ndone, 1);
    chk("left_in_queue", exp_q.size(), 0);
    chk("done_cycle", done_c, (n == 0) ? 1 : last_pop + 1);
    chk("addr_count", addr_seen.size(), (n == 0) ? 0 : int'(n));
    for (int i = 0; i < addr_seen.size() && i < int'(n); i++)
      chk("addr_seq", addr_seen[i], 14'(b + 14'(i)));
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [13:0] base;
    logic [14:0] len;
    int          mode;
    bit          extra;
    int          exp_first;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fv, dc, cyc, first2, done2_c, words2;
    logic [13:0] rb;
    logic [14:0] rn;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    base = '0; base2 = '0; len = '0; len2 = '0;
    s_if.READY_I = 1'b0; s2_if.READY_I = 1'b0;

    vecs[0] = '{14'h0010, 15'd8,  0, 1'b0,  3, 11};
    vecs[1] = '{14'h0010, 15'd8,  1, 1'b0,  3, -1};
    vecs[2] = '{14'h3FFE, 15'd4,  0, 1'b0,  3,  7};
    vecs[3] = '{14'h0000, 15'd0,  0, 1'b0, -1,  1};
    vecs[4] = '{14'h1234, 15'd1,  0, 1'b0,  3,  4};
    vecs[5] = '{14'h0200, 15'd16, 3, 1'b0,  3, 29};
    vecs[6] = '{14'h0020, 15'd8,  0, 1'b1,  3, 11};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", s_if.VALID_O, 0);
    chk("reset_data", s_if.DATA_O, 0);
    chk("reset_addr", rom_addr, 0);
    chk("reset_clk_en", rom_en, 0);
    chk("reset_valid2", s2_if.VALID_O, 0);

    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].extra, fv, dc);
      chk($sformatf("vec%0d_first_valid", v), fv, vecs[v].exp_first);
      if (vecs[v].exp_done >= 0) chk($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
    end

    for (int r = 0; r < 6; r++) begin
      rb = 14'($urandom_range(0, 16383));
      rn = 15'($urandom_range(0, 20));
      run_xfer(rb, rn, 2, 1'b0, fv, dc);
      chk("rand_first_valid", fv, (rn == 0) ? -1 : 3);
    end

    // Asynchronous reset in the middle of word 3 of a 16-word transfer.
    s_if.READY_I = 1'b1;
    base = 14'h0100; len = 15'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", s_if.VALID_O, 1);
    chk("pre_rst_data", s_if.DATA_O, rom_fn(14'h0102));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", s_if.VALID_O, 0);
    chk("rst_data", s_if.DATA_O, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_clk_en", rom_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_valid", s_if.VALID_O, 0);
      chk("post_rst_busy", busy, 0);
    end

    // RD_LAT=2 instance at full rate.
    base2 = 14'h0040; len2 = 15'd8; start2 = 1'b1;
    s2_if.READY_I = 1'b1;
    first2 = -1; done2_c = -1; words2 = 0; cyc = 0;
    @(negedge clk);
    start2 = 1'b0;
    while (cyc < 40 && done2_c < 0) begin
      cyc++;
      if (s2_if.VALID_O) begin
        if (first2 < 0) first2 = cyc;
        chk("lat2_data", s2_if.DATA_O, rom_fn(14'h0040 + 14'(words2)));
        words2++;
      end
      if (done2) done2_c = cyc;
      @(negedge clk);
    end
    chk("lat2_first_valid", first2, 4);
    chk("lat2_words", words2, 8);
    chk("lat2_done_cycle", done2_c, 12);
    chk("lat2_busy_after", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
